// File: rtl/fifo_reader_if.sv
// FIFO read port and output stream bundle for fifo_reader.
// The master modport is the reader; the slave side is the FIFO plus downstream sink.
interface fifo_reader_if #(
    parameter int unsigned data_width = 8
);
    logic [data_width-1:0] fifo_data;
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [data_width-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        input  fifo_data, fifo_empty, out_ready,
        output fifo_rd_en, out_data, out_valid
    );

    modport slave (
        output fifo_data, fifo_empty, out_ready,
        input  fifo_rd_en, out_data, out_valid
    );
endinterface

// File: rtl/fifo_reader.sv
// Burst reader: pulls len words from a 1-cycle-latency FIFO into a 2-entry
// output buffer and presents them as a valid/ready stream.
module fifo_reader #(
    parameter int unsigned data_width = 8,
    parameter int unsigned addr_width = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [addr_width-1:0] len,
    input  logic                  abort,
    fifo_reader_if.master         bus,
    output logic                  busy,
    output logic                  done,
    output logic [addr_width-1:0] remaining
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                state;
    logic [1:0]            cnt;
    logic                  pending;
    logic [data_width-1:0] head;
    logic [data_width-1:0] tail;
    logic                  pop;
    logic                  rd_en;

    // A read is allowed when buffer plus in-flight word leaves a slot free,
    // where a word retiring this cycle already counts as freed.
    always_comb begin
        pop   = (cnt != 2'd0) && bus.out_ready;
        rd_en = 1'b0;
        if (!rst && state == S_RUN && !abort && !bus.fifo_empty &&
            remaining != '0 &&
            (({1'b0, cnt} + {2'b0, pending}) < (3'd2 + {2'b0, pop})))
            rd_en = 1'b1;
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.out_valid  = (cnt != 2'd0);
    assign bus.out_data   = head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            pending   <= 1'b0;
            head      <= '0;
            tail      <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            pending <= rd_en;
            done    <= 1'b0;

            case ({pop, pending})
                2'b10: begin
                    head <= tail;
                    cnt  <= cnt - 2'd1;
                end
                2'b01: begin
                    if (cnt == 2'd0) head <= bus.fifo_data;
                    else             tail <= bus.fifo_data;
                    cnt <= cnt + 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        head <= bus.fifo_data;
                    end else begin
                        head <= tail;
                        tail <= bus.fifo_data;
                    end
                end
                default: ;
            endcase

            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        remaining <= len;
                        if (len == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        remaining <= '0;
                        cnt       <= '0;
                        pending   <= 1'b0;
                    end else if (rd_en) begin
                        remaining <= remaining - addr_width'(1);
                        if (remaining == addr_width'(1)) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        remaining <= '0;
                        cnt       <= '0;
                        pending   <= 1'b0;
                    end else if (cnt == 2'd0 && !pending) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: behavioural 1-cycle-latency FIFO, stream sink
// monitor, and one task per scenario with hand-computed expectations.
module tb_fifo_reader;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] len = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] remaining;

    fifo_reader_if #(.data_width(DW)) bus();

    fifo_reader #(.data_width(DW), .addr_width(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .abort     (abort),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         rd_count = 0;
    int         rd_while_empty = 0;
    int         done_count = 0;
    logic [7:0] got [$];
    int         tests = 0;
    int         fails = 0;

    assign bus.fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (bus.fifo_rd_en === 1'b1) begin
            if (rd_ptr == wr_ptr) rd_while_empty++;
            bus.fifo_data <= mem[rd_ptr[7:0]];
            rd_ptr        <= rd_ptr + 1;
            rd_count++;
        end
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) got.push_back(bus.out_data);
        if (done === 1'b1) done_count++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        mem[wr_ptr[7:0]] = v;
        wr_ptr++;
    endtask

    task automatic kick(input logic [AW-1:0] n);
        len   = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done === 1'b1) seen = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset;
        bus.out_ready = 1'b0;
        tick();
        tests++;
        if ({bus.fifo_rd_en, bus.out_valid, busy, done} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags: got %b want 0000", {bus.fifo_rd_en, bus.out_valid, busy, done});
        end
        tests++;
        if (bus.out_data !== 8'd0) begin
            fails++;
            $display("FAIL reset_data: got %0d want 0", bus.out_data);
        end
        tests++;
        if (remaining !== 8'd0) begin
            fails++;
            $display("FAIL reset_remaining: got %0d want 0", remaining);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        logic [7:0] o_rd, o_ov, o_done, o_busy;
        logic [7:0] dat [3];
        int d0;
        got.delete();
        d0 = done_count;
        push(8'd1); push(8'd2); push(8'd3);
        bus.out_ready = 1'b1;
        kick(8'd3);
        for (int k = 0; k < 8; k++) begin
            o_rd[k]   = bus.fifo_rd_en;
            o_ov[k]   = bus.out_valid;
            o_done[k] = done;
            o_busy[k] = busy;
            if (k >= 2 && k <= 4) dat[k-2] = bus.out_data;
            tick();
        end
        tests++;
        if (o_rd !== 8'b0000_0111) begin
            fails++;
            $display("FAIL basic_rd_en: got %b want 00000111", o_rd);
        end
        tests++;
        if (o_ov !== 8'b0001_1100) begin
            fails++;
            $display("FAIL basic_out_valid: got %b want 00011100", o_ov);
        end
        tests++;
        if ({dat[0], dat[1], dat[2]} !== {8'd1, 8'd2, 8'd3}) begin
            fails++;
            $display("FAIL basic_data: got %0d %0d %0d want 1 2 3", dat[0], dat[1], dat[2]);
        end
        tests++;
        if (o_done !== 8'b0100_0000 || done_count - d0 != 1) begin
            fails++;
            $display("FAIL basic_done: got %b (%0d pulses) want 01000000 (1)", o_done, done_count - d0);
        end
        tests++;
        if (o_busy !== 8'b0111_1111) begin
            fails++;
            $display("FAIL basic_busy: got %b want 01111111", o_busy);
        end
    endtask

    task automatic test_gap;
        logic [7:0] exp [4] = '{8'd10, 8'd11, 8'd12, 8'd13};
        bit bad_rd, bad_rem, bad, seen;
        int d0;
        got.delete();
        d0 = done_count;
        bad_rd = 1'b0;
        bad_rem = 1'b0;
        push(8'd10); push(8'd11);
        kick(8'd4);
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            if (bus.fifo_rd_en !== 1'b0) bad_rd = 1'b1;
            if (remaining !== 8'd2) bad_rem = 1'b1;
            tick();
        end
        tests++;
        if (bad_rd) begin
            fails++;
            $display("FAIL gap_rd_en: got 1 want 0 while FIFO empty");
        end
        tests++;
        if (bad_rem) begin
            fails++;
            $display("FAIL gap_remaining: got %0d want 2", remaining);
        end
        push(8'd12); push(8'd13);
        wait_done(seen);
        tick();
        tests++;
        if (!seen || done_count - d0 != 1) begin
            fails++;
            $display("FAIL gap_done: got seen=%0d pulses=%0d want 1 1", seen, done_count - d0);
        end
        bad = (got.size() != 4);
        for (int i = 0; i < 4 && !bad; i++) if (got[i] !== exp[i]) bad = 1'b1;
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL gap_words: got %0d words want 10 11 12 13", got.size());
        end
        tests++;
        if (rd_while_empty != 0) begin
            fails++;
            $display("FAIL gap_rd_empty: got %0d reads while empty want 0", rd_while_empty);
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] exp [5] = '{8'd20, 8'd21, 8'd22, 8'd23, 8'd24};
        bit bad_hold, bad, seen;
        int rc0;
        got.delete();
        bad_hold = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'(20 + i));
        kick(8'd5);
        rc0 = rd_count;
        for (int k = 0; k < 6; k++) begin
            if (k >= 2 && (bus.out_valid !== 1'b1 || bus.out_data !== 8'd20)) bad_hold = 1'b1;
            tick();
        end
        tests++;
        if (rd_count - rc0 != 2) begin
            fails++;
            $display("FAIL bp_reads: got %0d want 2", rd_count - rc0);
        end
        tests++;
        if (bad_hold) begin
            fails++;
            $display("FAIL bp_hold: got data %0d valid %b want 20 1", bus.out_data, bus.out_valid);
        end
        tests++;
        if (remaining !== 8'd3) begin
            fails++;
            $display("FAIL bp_remaining: got %0d want 3", remaining);
        end
        bus.out_ready = 1'b1;
        wait_done(seen);
        tick();
        bad = !seen || (got.size() != 5);
        for (int i = 0; i < 5 && !bad; i++) if (got[i] !== exp[i]) bad = 1'b1;
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL bp_words: got %0d words seen=%0d want 20..24 and done", got.size(), seen);
        end
    endtask

    task automatic test_len_zero;
        int rc0;
        rc0 = rd_count;
        kick(8'd0);
        tests++;
        if ({done, busy, bus.fifo_rd_en} !== 3'b110) begin
            fails++;
            $display("FAIL len0_pulse: got %b want 110", {done, busy, bus.fifo_rd_en});
        end
        tick();
        tests++;
        if ({done, busy} !== 2'b00 || rd_count != rc0) begin
            fails++;
            $display("FAIL len0_after: got %b reads %0d want 00 reads 0", {done, busy}, rd_count - rc0);
        end
    endtask

    task automatic test_reset_mid;
        bit seen;
        int d0;
        for (int i = 0; i < 4; i++) push(8'(40 + i));
        kick(8'd6);
        tick();
        tick();
        tests++;
        if ({busy, bus.out_valid, bus.fifo_rd_en} !== 3'b111) begin
            fails++;
            $display("FAIL rstmid_pre: got %b want 111", {busy, bus.out_valid, bus.fifo_rd_en});
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({bus.fifo_rd_en, bus.out_valid, busy, done} !== 4'b0000 ||
            bus.out_data !== 8'd0 || remaining !== 8'd0) begin
            fails++;
            $display("FAIL rstmid_async: got flags %b data %0d rem %0d want 0000 0 0",
                     {bus.fifo_rd_en, bus.out_valid, busy, done}, bus.out_data, remaining);
        end
        tick();
        rst = 1'b0;
        tick();
        tests++;
        if ({busy, done} !== 2'b00) begin
            fails++;
            $display("FAIL rstmid_idle: got %b want 00", {busy, done});
        end
        got.delete();
        d0 = done_count;
        kick(8'd2);
        wait_done(seen);
        tick();
        tests++;
        if (!seen || done_count - d0 != 1 || got.size() != 2 || got[0] !== 8'd42 || got[1] !== 8'd43) begin
            fails++;
            $display("FAIL rstmid_restart: got %0d words seen=%0d want 42 43 and done", got.size(), seen);
        end
    endtask

    task automatic test_abort;
        bit seen;
        int d0;
        got.delete();
        d0 = done_count;
        for (int i = 0; i < 8; i++) push(8'(30 + i));
        bus.out_ready = 1'b1;
        kick(8'd8);
        tick();
        tick();
        tick();
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd31) begin
            fails++;
            $display("FAIL abort_pre: got valid %b data %0d want 1 31", bus.out_valid, bus.out_data);
        end
        abort = 1'b1;
        #1;
        tests++;
        if (bus.fifo_rd_en !== 1'b0) begin
            fails++;
            $display("FAIL abort_rd_en: got %b want 0", bus.fifo_rd_en);
        end
        tick();
        abort = 1'b0;
        tests++;
        if ({busy, done, bus.out_valid} !== 3'b000 || remaining !== 8'd0) begin
            fails++;
            $display("FAIL abort_idle: got %b rem %0d want 000 rem 0", {busy, done, bus.out_valid}, remaining);
        end
        kick(8'd1);
        wait_done(seen);
        tick();
        tests++;
        if (!seen || done_count - d0 != 1) begin
            fails++;
            $display("FAIL abort_done: got seen=%0d pulses=%0d want 1 1", seen, done_count - d0);
        end
        tests++;
        if (got.size() != 3 || got[0] !== 8'd30 || got[1] !== 8'd31 || got[2] !== 8'd33) begin
            fails++;
            $display("FAIL abort_words: got %0d words want 30 31 33", got.size());
        end
        tests++;
        if (rd_while_empty != 0) begin
            fails++;
            $display("FAIL abort_rd_empty: got %0d reads while empty want 0", rd_while_empty);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_backpressure();
        test_len_zero();
        test_reset_mid();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter data_width, default 8, word width of the FIFO read port and the output stream.
REQ-002 SHALL have parameter addr_width, default 8, width of len and remaining.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to read a burst; honoured only in IDLE.
REQ-006 SHALL have port len  input  addr_width  burst length in words, sampled when start is honoured.
REQ-007 SHALL have port abort  input  1  terminates the current burst.
REQ-008 SHALL have port fifo_data  input  data_width  FIFO data_out.
REQ-009 SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-010 SHALL have port fifo_rd_en  output  1  FIFO read enable.
REQ-011 SHALL have port out_data  output  data_width  stream data.
REQ-012 SHALL have port out_valid  output  1  out_data holds a word.
REQ-013 SHALL have port out_ready  input  1  downstream accepts the word.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse when a burst completes normally.
REQ-016 SHALL have port remaining  output  addr_width  words not yet issued to the FIFO in the current burst.

Function
REQ-017 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-018 IDLE: when start=1, SHALL load remaining with len and go to RUN; if len=0, SHALL go directly to DONE.
REQ-019 SHALL treat the FIFO read latency as one cycle: fifo_data is valid in the cycle after the edge that sampled fifo_rd_en=1.
REQ-020 SHALL keep a 2-entry output buffer and a pending flag, which is fifo_rd_en registered.
REQ-021 SHALL drive fifo_rd_en combinationally, high only when: state is RUN, fifo_empty=0, remaining>0, and (buffer occupancy + pending) < 2, counting a same-cycle out_valid&&out_ready pop as freeing a slot.
REQ-022 SHALL never assert fifo_rd_en while fifo_empty=1, in states other than RUN, or during reset.
REQ-023 Each issued read SHALL decrement remaining by 1; when remaining reaches 0, the state SHALL go from RUN to DRAIN.
REQ-024 When pending=1, SHALL write fifo_data into the buffer tail in the same cycle; the buffer SHALL never overflow.
REQ-025 out_data SHALL be the buffer head, out_valid=1 iff the buffer is non-empty, and a word SHALL retire on out_valid&&out_ready.
REQ-026 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-027 SHALL preserve word order exactly as read from the FIFO; simultaneous capture and retire SHALL be legal in the same cycle.
REQ-028 DRAIN: when the buffer is empty and pending=0, SHALL go to DONE.
REQ-029 DONE: SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-030 abort in RUN or DRAIN SHALL stop issuing reads that cycle, discard buffered and pending words, force remaining to 0, and go to IDLE next cycle without a done pulse.
REQ-031 start SHALL be ignored outside IDLE; abort SHALL be ignored in IDLE and DONE.
REQ-032 Sustained throughput SHALL be 1 word per clock when fifo_empty=0 and out_ready=1.
REQ-033 The latency from start to the first out_valid SHALL be 2 cycles when the FIFO is non-empty.

Reset
REQ-034 On rst=1, SHALL immediately drive: state IDLE, fifo_rd_en=0, out_valid=0, out_data=0, busy=0, done=0, remaining=0, buffer and pending cleared.
REQ-035 Reset mid-burst SHALL drop all words and leave the block in IDLE after deassertion, with no done pulse.

Verification
REQ-036 FIFO preloaded 1,2,3, out_ready=1, start with len=3 -> fifo_rd_en high 3 consecutive cycles; out_data 1,2,3 on consecutive cycles; done pulses once; busy falls with the DONE-to-IDLE transition.
REQ-037 len=4 with only 2 words present, then 2 more pushed 5 cycles later -> fifo_rd_en stays 0 while fifo_empty=1; remaining holds 2 during the gap; all 4 words are delivered in order; done follows.
REQ-038 len=5 with out_ready=0 for 6 cycles -> at most 2 reads are issued; out_data stays at the first word; no loss or duplication after out_ready=1.
REQ-039 start with len=0 -> no fifo_rd_en; done pulses 1 cycle after start.
REQ-040 abort after 2 of 8 words, then start with len=1 -> no done for the aborted burst; remaining=0; the new burst delivers the next FIFO word.
REQ-041 rst asserted asynchronously mid-burst -> all outputs reach reset values before the next clock edge; start after release works normally.
